// File: rtl/vga_timing.sv
// VGA raster timing generator: issues pixel requests, re-aligns the returned colour
// with delayed sync/blanking, and drives registered r/g/b/hs/vs pins.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       hs,
  output logic       vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Bit 0 is the request stage; bit PIX_LAT lines up with the returned colour.
  logic [PIX_LAT:0] act_pipe_q, act_pipe_d;
  logic [PIX_LAT:0] hs_pipe_q, hs_pipe_d;
  logic [PIX_LAT:0] vs_pipe_q, vs_pipe_d;

  logic [3:0] r_q, r_d;
  logic [3:0] g_q, g_d;
  logic [3:0] b_q, b_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;

  logic visible;
  logic hs_dec;
  logic vs_dec;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end

    visible = (h_q < H_VIS) && (v_q < V_VIS);
    hs_dec  = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    vs_dec  = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

    x_d           = visible ? h_q : '0;
    y_d           = visible ? v_q : '0;
    line_start_d  = (h_q == '0);
    frame_start_d = (h_q == '0) && (v_q == '0);

    act_pipe_d[0] = visible;
    hs_pipe_d[0]  = hs_dec;
    vs_pipe_d[0]  = vs_dec;
    for (int i = 1; i <= PIX_LAT; i++) begin
      act_pipe_d[i] = act_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end

    // Colour is masked, not merely passed, so a source that ignores blanking stays dark.
    r_d  = act_pipe_q[PIX_LAT] ? r_in : '0;
    g_d  = act_pipe_q[PIX_LAT] ? g_in : '0;
    b_d  = act_pipe_q[PIX_LAT] ? b_in : '0;
    hs_d = hs_pipe_q[PIX_LAT] ? HS_POL : ~HS_POL;
    vs_d = vs_pipe_q[PIX_LAT] ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = act_pipe_q[0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hs          = hs_q;
  assign vs          = vs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default timing, and a shrunken raster at
// PIX_LAT 3 and 0) compared every cycle against an arithmetic raster model.
module tb_vga_timing;

  typedef struct packed {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
    bit hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x, y;
    logic       act, ls, fs;
    logic [3:0] r, g, b;
    logic       hs, vs;
  } obs_t;

  localparam cfg_t CFG_DEF = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33,
                               lat:1, hpol:1'b0, vpol:1'b0};
  localparam cfg_t CFG_S3  = '{ha:20, hfp:3, hsw:5, hbp:4, va:12, vfp:2, vsw:2, vbp:3,
                               lat:3, hpol:1'b1, vpol:1'b0};
  localparam cfg_t CFG_S0  = '{ha:20, hfp:3, hsw:5, hbp:4, va:12, vfp:2, vsw:2, vbp:3,
                               lat:0, hpol:1'b0, vpol:1'b1};
  localparam int NREC = 1700;

  logic clk = 1'b0;
  logic rst_n;
  int   n_edges;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [11:0] lut [0:255];
  logic [11:0] hist_def [0:4];
  logic [11:0] hist_s3 [0:4];
  logic [11:0] hist_s0 [0:4];

  logic [9:0] def_x, def_y, s3_x, s3_y, s0_x, s0_y;
  logic def_active, def_ls, def_fs, s3_active, s3_ls, s3_fs, s0_active, s0_ls, s0_fs;
  logic [3:0] def_r_in, def_g_in, def_b_in, s3_r_in, s3_g_in, s3_b_in, s0_r_in, s0_g_in, s0_b_in;
  logic [3:0] def_r, def_g, def_b, s3_r, s3_g, s3_b, s0_r, s0_g, s0_b;
  logic def_hs, def_vs, s3_hs, s3_vs, s0_hs, s0_vs;
  obs_t o_def, o_s3, o_s0;

  bit def_ls_rec [1:NREC];
  bit def_lit_rec [1:NREC];
  bit def_hs_rec [1:NREC];
  bit s3_fs_rec [1:NREC];
  bit s3_ls_rec [1:NREC];
  bit s3_act_rec [1:NREC];
  bit s3_vs_rec [1:NREC];
  bit s0_lit_rec [1:NREC];

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(1)
  ) dut_def (
    .clk(clk), .rst_n(rst_n), .x(def_x), .y(def_y), .active(def_active),
    .line_start(def_ls), .frame_start(def_fs),
    .r_in(def_r_in), .g_in(def_g_in), .b_in(def_b_in),
    .r(def_r), .g(def_g), .b(def_b), .hs(def_hs), .vs(def_vs)
  );

  vga_timing #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIX_LAT(3)
  ) dut_s3 (
    .clk(clk), .rst_n(rst_n), .x(s3_x), .y(s3_y), .active(s3_active),
    .line_start(s3_ls), .frame_start(s3_fs),
    .r_in(s3_r_in), .g_in(s3_g_in), .b_in(s3_b_in),
    .r(s3_r), .g(s3_g), .b(s3_b), .hs(s3_hs), .vs(s3_vs)
  );

  vga_timing #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIX_LAT(0)
  ) dut_s0 (
    .clk(clk), .rst_n(rst_n), .x(s0_x), .y(s0_y), .active(s0_active),
    .line_start(s0_ls), .frame_start(s0_fs),
    .r_in(s0_r_in), .g_in(s0_g_in), .b_in(s0_b_in),
    .r(s0_r), .g(s0_g), .b(s0_b), .hs(s0_hs), .vs(s0_vs)
  );

  assign o_def = {def_x, def_y, def_active, def_ls, def_fs, def_r, def_g, def_b, def_hs, def_vs};
  assign o_s3  = {s3_x, s3_y, s3_active, s3_ls, s3_fs, s3_r, s3_g, s3_b, s3_hs, s3_vs};
  assign o_s0  = {s0_x, s0_y, s0_active, s0_ls, s0_fs, s0_r, s0_g, s0_b, s0_hs, s0_vs};

  // Rising edges seen since the last reset release; edge 1 is the first after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  function automatic logic [11:0] colour(input int h, input int v);
    return lut[((v % 16) * 16) + (h % 16)];
  endfunction

  // Raster model: edge n shows the request for count n-1, pins show count n-lat-2.
  function automatic obs_t model(input cfg_t c, input int n);
    obs_t o;
    int   ht, vt, k, h, v;
    bit   vis;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    o = '0;
    o.hs = ~c.hpol;
    o.vs = ~c.vpol;
    if (n >= 1) begin
      k = n - 1;
      h = k % ht;
      v = (k / ht) % vt;
      vis = (h < c.ha) && (v < c.va);
      o.act = vis;
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
      if (vis) begin
        o.x = 10'(h);
        o.y = 10'(v);
      end
    end
    if (n >= c.lat + 2) begin
      k = n - c.lat - 2;
      h = k % ht;
      v = (k / ht) % vt;
      vis = (h < c.ha) && (v < c.va);
      if (vis) {o.r, o.g, o.b} = colour(h, v);
      if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) o.hs = c.hpol;
      if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) o.vs = c.vpol;
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, n_edges);
    end
  endtask

  task automatic checkDut(input string tag, input cfg_t c, input obs_t a, input int n);
    obs_t e;
    e = model(c, n);
    checkOutput({tag, ".x"}, int'(a.x), int'(e.x));
    checkOutput({tag, ".y"}, int'(a.y), int'(e.y));
    checkOutput({tag, ".active"}, int'(a.act), int'(e.act));
    checkOutput({tag, ".line_start"}, int'(a.ls), int'(e.ls));
    checkOutput({tag, ".frame_start"}, int'(a.fs), int'(e.fs));
    checkOutput({tag, ".r"}, int'(a.r), int'(e.r));
    checkOutput({tag, ".g"}, int'(a.g), int'(e.g));
    checkOutput({tag, ".b"}, int'(a.b), int'(e.b));
    checkOutput({tag, ".hs"}, int'(a.hs), int'(e.hs));
    checkOutput({tag, ".vs"}, int'(a.vs), int'(e.vs));
  endtask

  // Pixel sources: each returns the LUT colour for the request seen PIX_LAT cycles ago.
  always @(negedge clk) begin
    for (int i = 4; i > 0; i--) begin
      hist_def[i] = hist_def[i-1];
      hist_s3[i]  = hist_s3[i-1];
      hist_s0[i]  = hist_s0[i-1];
    end
    hist_def[0] = colour(int'(def_x), int'(def_y));
    hist_s3[0]  = colour(int'(s3_x), int'(s3_y));
    hist_s0[0]  = colour(int'(s0_x), int'(s0_y));
    {def_r_in, def_g_in, def_b_in} = hist_def[CFG_DEF.lat];
    {s3_r_in, s3_g_in, s3_b_in}    = hist_s3[CFG_S3.lat];
    {s0_r_in, s0_g_in, s0_b_in}    = hist_s0[CFG_S0.lat];
  end

  always @(negedge clk) begin
    checkDut("def", CFG_DEF, o_def, n_edges);
    checkDut("s3", CFG_S3, o_s3, n_edges);
    checkDut("s0", CFG_S0, o_s0, n_edges);
  end

  function automatic int firstIdx(input bit arr [1:NREC], input int from, input bit val);
    for (int i = (from < 1) ? 1 : from; i <= NREC; i++)
      if (arr[i] == val) return i;
    return -1;
  endfunction

  function automatic int lastIdx(input bit arr [1:NREC], input int upto, input bit val);
    for (int i = (upto > NREC) ? NREC : upto; i >= 1; i--)
      if (arr[i] == val) return i;
    return -1;
  endfunction

  function automatic int countIdx(input bit arr [1:NREC], input int lo, input int hi, input bit val);
    int cnt = 0;
    for (int i = lo; i <= hi; i++)
      if (arr[i] == val) cnt++;
    return cnt;
  endfunction

  task automatic applyStimulus(input int run_cycles, input int hold_cycles);
    repeat (run_cycles) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (hold_cycles) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int fall, rise;
    rst_n = 1'b0;
    // Every channel nibble is nonzero so a lit pin always means a visible pixel.
    for (int i = 0; i < 256; i++)
      lut[i] = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
    for (int i = 0; i < 5; i++) begin
      hist_def[i] = '0;
      hist_s3[i]  = '0;
      hist_s0[i]  = '0;
    end

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 1; i <= NREC; i++) begin
      @(posedge clk);
      @(negedge clk);
      def_ls_rec[i]  = def_ls;
      def_lit_rec[i] = (def_r != 4'h0);
      def_hs_rec[i]  = def_hs;
      s3_fs_rec[i]   = s3_fs;
      s3_ls_rec[i]   = s3_ls;
      s3_act_rec[i]  = s3_active;
      s3_vs_rec[i]   = s3_vs;
      s0_lit_rec[i]  = (s0_r != 4'h0);
    end

    checkOutput("def.first_line_start", firstIdx(def_ls_rec, 1, 1'b1), 1);
    checkOutput("def.line_period", firstIdx(def_ls_rec, 2, 1'b1) - 1, 800);
    checkOutput("def.first_lit_pin", firstIdx(def_lit_rec, 1, 1'b1), 3);
    checkOutput("def.lit_per_line", countIdx(def_lit_rec, 1, 800, 1'b1), 640);
    fall = firstIdx(def_hs_rec, 1, 1'b0);
    rise = firstIdx(def_hs_rec, fall + 1, 1'b1);
    checkOutput("def.hs_fall_edge", fall, 659);
    checkOutput("def.hs_width", rise - fall, 96);
    checkOutput("def.front_porch_pins", fall - lastIdx(def_lit_rec, fall - 1, 1'b1) - 1, 16);
    checkOutput("def.back_porch_pins", firstIdx(def_lit_rec, rise, 1'b1) - rise, 48);

    checkOutput("s3.first_frame_start", firstIdx(s3_fs_rec, 1, 1'b1), 1);
    checkOutput("s3.frame_period", firstIdx(s3_fs_rec, 2, 1'b1) - 1, 608);
    checkOutput("s3.lines_per_frame", countIdx(s3_ls_rec, 1, 608, 1'b1), 19);
    checkOutput("s3.active_per_frame", countIdx(s3_act_rec, 1, 608, 1'b1), 240);
    fall = firstIdx(s3_vs_rec, 1, 1'b0);
    rise = firstIdx(s3_vs_rec, fall + 1, 1'b1);
    checkOutput("s3.vs_fall_edge", fall, 453);
    checkOutput("s3.vs_width", rise - fall, 64);

    checkOutput("s0.first_lit_pin", firstIdx(s0_lit_rec, 1, 1'b1), 2);

    for (int i = 0; i < 5; i++)
      applyStimulus(int'($urandom_range(150, 3000)), int'($urandom_range(1, 4)));

    repeat (20000) @(posedge clk);
    @(negedge clk);
    $display("[TB] run complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
